// File: rtl/pc_sequencer.sv
// Multicycle control sequencer for the single-memory MIPS datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives the shared
// memory port and PC/IR/register-file enables, counts retired instructions and
// halts with a sticky error on an illegal opcode or a stalled memory handshake.
module pc_sequencer #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpHalt  = 6'h3F;

    localparam logic [1:0] PcPlus4  = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

    // Wide enough to hold TIMEOUT itself, the value reached on the expiring cycle.
    localparam int unsigned     WaitW    = $clog2(TIMEOUT + 1);
    // wait_cnt_q counts earlier waited cycles, so this value marks the TIMEOUT-th one.
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               err_q, err_d;

    logic               waiting;
    logic               timeout_hit;
    logic               retire;
    logic               set_err;

    assign state       = state_q;
    assign err         = err_q;
    assign instr_count = instr_count_q;

    // A memory visit is stalling; the expiring cycle still loses to mem_ready.
    assign waiting     = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign timeout_hit = waiting && (wait_cnt_q >= WaitLast);

    // Next-state decode and control outputs from the current state and IR opcode.
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PcPlus4;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;
        set_err    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                mem_req = 1'b1;
                mem_rd  = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PcPlus4;
                    state_d  = StDecode;
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_d = StHalt;
                end
            end

            StDecode: begin
                case (opcode)
                    OpJ: begin
                        pc_write = 1'b1;
                        pc_src   = PcJump;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    OpHalt: begin
                        retire  = 1'b1;
                        state_d = StHalt;
                    end
                    OpRtype, OpBeq, OpAddi, OpLw, OpSw: begin
                        state_d = StExec;
                    end
                    default: begin
                        set_err = 1'b1;
                        state_d = StHalt;
                    end
                endcase
            end

            StExec: begin
                case (opcode)
                    OpBeq: begin
                        pc_write = zero;
                        pc_src   = PcBranch;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    OpRtype, OpAddi: begin
                        state_d = StWb;
                    end
                    OpLw, OpSw: begin
                        state_d = StMem;
                    end
                    default: begin
                        // IR should not change after DECODE; treat it as illegal anyway.
                        set_err = 1'b1;
                        state_d = StHalt;
                    end
                endcase
            end

            StMem: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_rd  = (opcode == OpLw);
                mem_wr  = (opcode == OpSw);
                if (mem_ready) begin
                    if (opcode == OpLw) begin
                        state_d = StWb;
                    end else begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end
                end else if (timeout_hit) begin
                    set_err = 1'b1;
                    state_d = StHalt;
                end
            end

            StWb: begin
                reg_write  = 1'b1;
                reg_dst    = (opcode == OpRtype);
                mem_to_reg = (opcode == OpLw);
                retire     = 1'b1;
                state_d    = StFetch;
            end

            StHalt: begin
                halted = 1'b1;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Bookkeeping next-state: handshake wait counter, sticky error, retire counter.
    always_comb begin
        wait_cnt_d    = waiting ? (wait_cnt_q + WaitW'(1)) : '0;
        err_d         = err_q | set_err;
        instr_count_d = retire ? (instr_count_q + CNT_W'(1)) : instr_count_q;
    end

    // State registers with synchronous reset that overrides every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            instr_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_count_q <= instr_count_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multicycle control FSM that sequences the PC register and the shared instruction/data memory port for the single-memory MIPS datapath.
- Per instruction, it decides when the PC is written and which next-PC source is used (PC+4, branch target, jump target).
- It decides when the memory is accessed and when the IR and register file are written.
- It tracks retired instructions and detects memory-handshake timeouts.

Parameters:
- CNT_W, 16, width of retired-instruction counter instr_count.
- TIMEOUT, 255, maximum cycles spent waiting for mem_ready in one FETCH/MEM visit before error halt (must be at least 1).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  begin execution; sampled only in IDLE.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- zero  in  1  ALU zero flag; valid in EXEC.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request active.
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC this cycle.
- pc_src  out  2  next-PC select: 00=PC+4, 01=branch target, 10=jump target.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1=rd, 0=rt.
- mem_to_reg  out  1  1=MDR, 0=ALUOut.
- state  out  3  current state encoding.
- halted  out  1  high in HALT.
- err  out  1  sticky error: illegal opcode or timeout.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (sync, rst=1 at a clock edge):
  - State goes to IDLE. wait_cnt, instr_count and err go to 0.
  - All outputs are 0 while in IDLE.
  - rst overrides every other input, including mid-memory handshake.
- Output timing:
  - All control outputs are combinational decodes of state, plus opcode, zero and mem_ready where noted.
  - Every output not named for a state is 0.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Recognised opcodes:
  - RTYPE=0x00, J=0x02, BEQ=0x04, ADDI=0x08, LW=0x23, SW=0x2B, HALT=0x3F.
  - Any other opcode is illegal.
- IDLE: Start=1 goes to FETCH; otherwise stay in IDLE.
- FETCH:
  - Drives mem_req=1, mem_rd=1, iord=0.
  - If mem_ready=0: stay in FETCH.
  - If mem_ready=1: in the same cycle assert ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
- DECODE:
  - J: pc_write=1, pc_src=10, go to FETCH (J retires).
  - HALT opcode: go to HALT; retires; err unchanged.
  - Illegal opcode: set err=1, go to HALT; does not retire.
  - Otherwise: go to EXEC.
- EXEC:
  - BEQ: pc_write=zero, pc_src=01, go to FETCH (retires).
  - RTYPE/ADDI: go to WB.
  - LW/SW: go to MEM.
- MEM:
  - Drives mem_req=1, iord=1; mem_rd=1 for LW, mem_wr=1 for SW.
  - Hold in MEM until mem_ready=1.
  - Then LW goes to WB; SW goes to FETCH (retires).
- WB:
  - reg_write=1.
  - reg_dst=1 only for RTYPE; mem_to_reg=1 only for LW.
  - Go to FETCH (retires).
- HALT:
  - halted=1. Stay until rst; Start is ignored.
- Retire counting:
  - instr_count increments by 1 on each retiring transition.
  - Wraps modulo 2^CNT_W with no saturation.
- Timeout:
  - wait_cnt clears on every entry to FETCH/MEM and increments each cycle waited there with mem_ready=0.
  - If wait_cnt reaches TIMEOUT while mem_ready=0: set err=1, go to HALT, drop mem_req next cycle.
  - mem_ready=1 in the same cycle that the count is reached counts as a success.
- Start outside IDLE has no effect. mem_ready outside FETCH/MEM is ignored.

Test Plan:
- Reset 3 cycles, then Start=1 with mem_ready=1 every cycle and opcode=0x00 → states 1,2,3,5,1; pc_write=1 only in the FETCH cycle with pc_src=00; reg_write=reg_dst=1 in WB; instr_count=1.
- BEQ 0x04 twice, first with zero=1 then with zero=0 → EXEC pc_write=1/pc_src=01 the first time, pc_write=0 the second; each takes 3 cycles; instr_count +2.
- LW 0x23 with mem_ready delayed 4 cycles in MEM → mem_req=iord=mem_rd=1 held 5 cycles, then WB with mem_to_reg=1; followed by SW 0x2B → mem_wr=1, no WB state, returns to FETCH.
- J 0x02, then opcode 0x3F → J: DECODE pc_write=1, pc_src=10. HALT: halted=1, err=0, Start=1 ignored; instr_count=2.
- Opcode 0x11 (illegal) → HALT with err=1, instr_count unchanged. Separately, mem_ready held 0 in FETCH with TIMEOUT=4 → HALT after 4 wait cycles with err=1.
- rst asserted mid-MEM wait → next cycle state=0, mem_req=0, instr_count=0, err=0. Also preload instr_count to 0xFFFF (CNT_W=16) and retire 1 → 0x0000.
